regfile_mp_sb: RTL
==================

Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file with a built-in pending-write scoreboard. It serves the pipelined core with NUM_RP combinational read ports and NUM_WP synchronous write ports, each read port having write-through bypass. Per-register pending counters track in-flight producers issued from decode. Busy flags let the hazard unit stall until the operand is written or bypassed.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of two, >=2)
NUM_RP, 2, number of read ports
NUM_WP, 1, number of write ports
CNT_W, 2, pending-counter width; max in-flight producers per register = 2^CNT_W-1
AW, $clog2(NREG), address width (derived, not overridden)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
rs_addr_i  in  NUM_RP x AW  read addresses
rs_data_o  out  NUM_RP x XLEN  read data (bypassed)
rs_busy_o  out  NUM_RP  operand still pending after this cycle's writebacks
wr_en_i  in  NUM_WP  write enables
wr_addr_i  in  NUM_WP x AW  write addresses
wr_data_i  in  NUM_WP x XLEN  write data
iss_valid_i  in  1  decode issues an instruction writing iss_addr_i
iss_addr_i  in  AW  destination of issued instruction
iss_ready_o  out  1  issue accepted this cycle
flush_i  in  1  pipeline flush; discard all pending counts
underflow_o  out  1  sticky: writeback to register with zero pending count

Behaviour:
- Reset (async, rst_n_i=0): all registers 0, all pending counters 0, underflow_o=0. Reset mid-operation drops all pending state immediately.
- Register 0 hard-wired: reads return 0, writes ignored, never busy, issues to 0 always accepted and not counted.
- Write: at posedge, for each port w with wr_en_i[w] and wr_addr_i[w]!=0, reg[addr] <= data. If several ports hit the same address, the highest port index wins.
- Read: combinational, zero latency. If any write port has wr_en and nonzero matching address, return its wr_data (highest index wins). Otherwise return the array value.
- Pending counter cnt[r], CNT_W bits, r=1..NREG-1. Each edge: cnt[r] <= cnt[r] + inc - dec.
  - inc = 1 if issue fires (iss_valid_i & iss_ready_o) with iss_addr_i==r.
  - dec = number of write ports with wr_en and addr==r.
- Issue and writeback to the same r in the same cycle: net change applies (e.g. cnt 1 -> 1).
- Underflow: if dec > cnt[r] (+inc), cnt[r] floors at 0 and underflow_o sets; it stays set until reset.
- iss_ready_o = (iss_addr_i==0) or cnt[iss_addr_i] != 2^CNT_W-1. It is combinational and independent of iss_valid_i. A writeback in the same cycle does not raise ready (conservative).
- rs_busy_o[p] = (rs_addr_i[p]!=0) and (cnt[addr] - dec_this_cycle[addr]) > 0.
  - Consequence: a single pending producer writing back this cycle is seen as not busy, and the data comes from the bypass.
  - An issue in the same cycle does not make a reader busy this cycle.
- flush_i: at posedge all counters <= 0. It overrides issue and decrement in that cycle. Register writes in that cycle still happen. underflow is not evaluated in a flush cycle.
- No X propagation: outputs fully defined for any address input.

Decomposition:
- Package regfile_pkg: XLEN/NREG defaults, derived AW, function for highest-index port match, typedef for the pending-counter vector.
- Sub-module regfile_scoreboard: holds pending counters, iss_ready_o, rs_busy_o and underflow logic.
- Data array and bypass muxes stay in the top.

Test Plan:
- Reset then read all registers on both ports -> all 0, rs_busy_o=00, iss_ready_o=1, underflow_o=0.
- wr_en=1, addr=5, data=0xDEADBEEF while rs_addr={5,0} -> same cycle rs_data={0xDEADBEEF,0}. Next cycle array read returns 0xDEADBEEF. Write to x0 with 0x1234 -> x0 reads 0.
- NUM_WP=2, both ports write x7 (0x11, 0x22) -> bypass and stored value both 0x22. Pending count for x7 of 2 drops to 0 in one edge.
- Issue x3 three times (CNT_W=2) -> cnt=3, fourth issue iss_ready_o=0. Read x3 -> busy=1. One writeback -> busy stays 1 with cnt 3->2. Final writeback at cnt=1 -> busy=0 same cycle, data bypassed.
- Issue x9, then flush_i together with a new issue of x9 and a writeback to x9 of 0x55 -> next cycle cnt[x9]=0, busy=0, reg x9=0x55.
- Writeback to x12 with cnt=0 -> underflow_o=1 next cycle and held. Assert rst_n_i low mid-sequence -> underflow_o, counters and registers clear asynchronously.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, the write-port priority helper and the pending-counter type
// for the multi-port register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREG_DEF  = 32;
    localparam int AW_DEF    = $clog2(NREG_DEF);
    localparam int CNT_W_DEF = 2;
    localparam int MAX_WP    = 8;

    typedef logic [NREG_DEF-1:0][CNT_W_DEF-1:0] cnt_vec_t;

    // Index of the highest set bit, -1 when none: the highest write port wins.
    function automatic int hi_match(input logic [MAX_WP-1:0] hit);
        int idx;
        idx = -1;
        for (int i = 0; i < MAX_WP; i++) begin
            if (hit[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Read, write, issue and status bundle between the core and the register file.
// Signal suffixes are named from the register file's point of view.
interface regfile_mp_sb_if #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NUM_RP = 2,
    parameter int NUM_WP = 1
);
    localparam int AW = $clog2(NREG);

    logic [NUM_RP-1:0][AW-1:0]   rs_addr_i;
    logic [NUM_RP-1:0][XLEN-1:0] rs_data_o;
    logic [NUM_RP-1:0]           rs_busy_o;
    logic [NUM_WP-1:0]           wr_en_i;
    logic [NUM_WP-1:0][AW-1:0]   wr_addr_i;
    logic [NUM_WP-1:0][XLEN-1:0] wr_data_i;
    logic                        iss_valid_i;
    logic [AW-1:0]               iss_addr_i;
    logic                        iss_ready_o;
    logic                        flush_i;
    logic                        underflow_o;

    modport slave (
        input  rs_addr_i, wr_en_i, wr_addr_i, wr_data_i,
        input  iss_valid_i, iss_addr_i, flush_i,
        output rs_data_o, rs_busy_o, iss_ready_o, underflow_o
    );

    modport master (
        output rs_addr_i, wr_en_i, wr_addr_i, wr_data_i,
        output iss_valid_i, iss_addr_i, flush_i,
        input  rs_data_o, rs_busy_o, iss_ready_o, underflow_o
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register in-flight producer counters: issue backpressure, operand busy
// flags and a sticky underflow flag for writebacks nobody announced.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int NUM_RP = 2,
    parameter int NUM_WP = 1,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int AW     = $clog2(NREG)
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [NUM_WP-1:0]         wr_en_i,
    input  logic [NUM_WP-1:0][AW-1:0] wr_addr_i,
    input  logic                      iss_valid_i,
    input  logic [AW-1:0]             iss_addr_i,
    input  logic                      flush_i,
    input  logic [NUM_RP-1:0][AW-1:0] rs_addr_i,
    output logic                      iss_ready_o,
    output logic [NUM_RP-1:0]         rs_busy_o,
    output logic                      underflow_o
);

    logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                       uf_q, uf_d;
    int                         dec [NREG];
    int                         nxt;

    always_comb begin
        cnt_d       = cnt_q;
        uf_d        = uf_q;
        nxt         = 0;
        dec         = '{default: 0};
        rs_busy_o   = '0;
        // Ready looks only at the current count, never at a same-cycle writeback.
        iss_ready_o = (iss_addr_i == '0) || (cnt_q[iss_addr_i] != '1);

        for (int r = 0; r < NREG; r++) begin
            for (int w = 0; w < NUM_WP; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w] == AW'(r))) dec[r] = dec[r] + 1;
            end
        end

        for (int r = 1; r < NREG; r++) begin
            nxt = int'(cnt_q[r]) - dec[r]
                + ((iss_valid_i && iss_ready_o && (iss_addr_i == AW'(r))) ? 1 : 0);
            if (flush_i) begin
                cnt_d[r] = '0;
            end else if (nxt < 0) begin
                cnt_d[r] = '0;
                uf_d     = 1'b1;
            end else begin
                cnt_d[r] = CNT_W'(nxt);
            end
        end

        // A producer retiring this cycle is covered by the bypass, so not busy.
        for (int p = 0; p < NUM_RP; p++) begin
            rs_busy_o[p] = (rs_addr_i[p] != '0)
                        && ((int'(cnt_q[rs_addr_i[p]]) - dec[rs_addr_i[p]]) > 0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            uf_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            uf_q  <= uf_d;
        end
    end

    assign underflow_o = uf_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-through bypass on every read port
// and a pending-write scoreboard for the hazard unit. x0 reads as zero.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int NUM_RP = 2,
    parameter int NUM_WP = 1,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int AW     = $clog2(NREG)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    regfile_mp_sb_if.slave bus
);

    logic [NREG-1:0][XLEN-1:0]     regs_q;
    logic [NUM_RP-1:0][MAX_WP-1:0] hit;

    // Later loop iterations override earlier ones, so the highest port wins.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            regs_q <= '0;
        end else begin
            for (int w = 0; w < NUM_WP; w++) begin
                if (bus.wr_en_i[w] && (bus.wr_addr_i[w] != '0)) begin
                    regs_q[bus.wr_addr_i[w]] <= bus.wr_data_i[w];
                end
            end
        end
    end

    always_comb begin
        hit           = '0;
        bus.rs_data_o = '0;
        for (int p = 0; p < NUM_RP; p++) begin
            for (int w = 0; w < NUM_WP; w++) begin
                hit[p][w] = bus.wr_en_i[w] && (bus.rs_addr_i[p] != '0)
                         && (bus.wr_addr_i[w] == bus.rs_addr_i[p]);
            end
            bus.rs_data_o[p] = regs_q[bus.rs_addr_i[p]];
            for (int w = 0; w < NUM_WP; w++) begin
                if (hi_match(hit[p]) == w) bus.rs_data_o[p] = bus.wr_data_i[w];
            end
        end
    end

    regfile_scoreboard #(
        .NREG   (NREG),
        .NUM_RP (NUM_RP),
        .NUM_WP (NUM_WP),
        .CNT_W  (CNT_W),
        .AW     (AW)
    ) u_sb (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .wr_en_i     (bus.wr_en_i),
        .wr_addr_i   (bus.wr_addr_i),
        .iss_valid_i (bus.iss_valid_i),
        .iss_addr_i  (bus.iss_addr_i),
        .flush_i     (bus.flush_i),
        .rs_addr_i   (bus.rs_addr_i),
        .iss_ready_o (bus.iss_ready_o),
        .rs_busy_o   (bus.rs_busy_o),
        .underflow_o (bus.underflow_o)
    );

endmodule
